// File: rtl/apb_master_ctrl_pkg.sv
// Shared types for the core-to-APB load/store path: FSM states and RV32I func3 size/sign codes.
package apb_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus bundle between the master controller and NUM_SLV slaves; PRDATA packs slave i at [32i+31:32i].
interface apb_master_ctrl_if #(
    parameter int NUM_SLV = 4
);
    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic [3:0]            PSTRB;
    logic [NUM_SLV-1:0]    PSEL;
    logic                  PENABLE;
    logic [32*NUM_SLV-1:0] PRDATA;
    logic [NUM_SLV-1:0]    PREADY;
    logic [NUM_SLV-1:0]    PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_lane_align.sv
// Combinational byte-lane steering: store strobes/replication, load extension, size/alignment legality.
// Zero latency; no flow control.
module apb_lane_align
    import apb_master_ctrl_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  pstrb,
    output logic [31:0] pwdata,
    output logic [31:0] rdata_ext,
    output logic        bad
);
    logic [31:0] shifted;

    assign shifted = rdata_raw >> {addr_lo, 3'b000};

    always_comb begin
        pstrb     = 4'b0000;
        pwdata    = wdata;
        rdata_ext = 32'h0;
        bad       = 1'b0;
        if (we) begin
            case (func3)
                F3_SB: begin
                    pstrb  = 4'b0001 << addr_lo;
                    pwdata = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    pstrb  = 4'b0011 << addr_lo;
                    pwdata = {2{wdata[15:0]}};
                    bad    = addr_lo[0];
                end
                F3_SW: begin
                    pstrb = 4'b1111;
                    bad   = |addr_lo;
                end
                default: bad = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
                F3_LBU:  rdata_ext = {24'h0, shifted[7:0]};
                F3_LH: begin
                    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
                    bad       = addr_lo[0];
                end
                F3_LHU: begin
                    rdata_ext = {16'h0, shifted[15:0]};
                    bad       = addr_lo[0];
                end
                F3_LW: begin
                    rdata_ext = rdata_raw;
                    bad       = |addr_lo;
                end
                default: bad = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master for core loads/stores: decode, SETUP/ACCESS sequencing, lane alignment.
// Zero-wait latency req->done is 3 cycles (+1 per wait state, bounded by TIMEOUT); req ignored while busy.
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          SLV_SHIFT = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    apb_master_ctrl_if.master apb
);
    localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int DW   = 32 - SLV_SHIFT;
    localparam int TW   = $clog2(TIMEOUT + 1);

    apb_state_e state, state_nxt;

    logic            we_q;
    logic [31:0]     addr_q;
    logic [2:0]      func3_q;
    logic [IDXW-1:0] idx_q;
    logic [3:0]      pstrb_q;
    logic [31:0]     pwdata_q;
    logic [TW-1:0]   tmo_cnt;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic [DW-1:0]      slv_diff;
    logic               hit, bad_req, tmo_hit;
    logic               sel_rdy, sel_err;
    logic [31:0]        sel_rdata;
    logic [NUM_SLV-1:0] psel_hot;

    logic        al_we, al_bad;
    logic [2:0]  al_func3;
    logic [1:0]  al_addr;
    logic [3:0]  al_pstrb;
    logic [31:0] al_pwdata, al_rdata;

    // Modular subtraction: addresses below the window wrap high and miss.
    assign slv_diff = addr[31:SLV_SHIFT] - BASE_ADDR[31:SLV_SHIFT];
    assign hit      = slv_diff < DW'(NUM_SLV);
    assign bad_req  = !hit || al_bad;

    // The aligner checks the live request in IDLE and extends read data from the latched one afterwards.
    assign al_we    = (state == ST_IDLE) ? we         : we_q;
    assign al_func3 = (state == ST_IDLE) ? func3      : func3_q;
    assign al_addr  = (state == ST_IDLE) ? addr[1:0]  : addr_q[1:0];

    apb_lane_align u_align (
        .we        (al_we),
        .func3     (al_func3),
        .addr_lo   (al_addr),
        .wdata     (wdata),
        .rdata_raw (sel_rdata),
        .pstrb     (al_pstrb),
        .pwdata    (al_pwdata),
        .rdata_ext (al_rdata),
        .bad       (al_bad)
    );

    always_comb begin
        sel_rdata = 32'h0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IDXW'(i)) sel_rdata = apb.PRDATA[32*i +: 32];
        end
    end

    assign sel_rdy  = apb.PREADY[idx_q];
    assign sel_err  = apb.PSLVERR[idx_q];
    assign psel_hot = NUM_SLV'(1) << idx_q;
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        apb.PSEL    = '0;
        apb.PENABLE = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (req) state_nxt = bad_req ? ST_RESP : ST_SETUP;
            end
            ST_SETUP: begin
                apb.PSEL  = psel_hot;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                apb.PSEL    = psel_hot;
                apb.PENABLE = 1'b1;
                if (sel_rdy || tmo_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            func3_q  <= 3'h0;
            idx_q    <= '0;
            pstrb_q  <= 4'h0;
            pwdata_q <= 32'h0;
            tmo_cnt  <= '0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        err_q   <= bad_req;
                        rdata_q <= 32'h0;
                        tmo_cnt <= '0;
                        // Rejected requests leave the bus-facing registers untouched.
                        if (!bad_req) begin
                            we_q     <= we;
                            addr_q   <= addr;
                            func3_q  <= func3;
                            idx_q    <= slv_diff[IDXW-1:0];
                            pstrb_q  <= al_pstrb;
                            pwdata_q <= al_pwdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_rdy) begin
                        err_q   <= sel_err;
                        rdata_q <= (we_q || sel_err) ? 32'h0 : al_rdata;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign apb.PADDR  = addr_q;
    assign apb.PWRITE = we_q;
    assign apb.PSTRB  = pstrb_q;
    assign apb.PWDATA = pwdata_q;
    assign rdata      = done ? rdata_q : 32'h0;
    assign err        = done & err_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Randomized bench for apb_master_ctrl with an address-arithmetic reference model and a reactive APB slave driver.
module tb_apb_master_ctrl;
    import apb_master_ctrl_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int NSLV = 4;
    localparam int TMO  = 255;

    logic clk, reset, req, we, done, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic [2:0] func3;

    apb_master_ctrl_if #(.NUM_SLV(NSLV)) apb ();

    apb_master_ctrl #(
        .NUM_SLV(NSLV), .BASE_ADDR(BASE), .SLV_SHIFT(12), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .func3(func3), .rdata(rdata), .done(done), .err(err), .busy(busy), .apb(apb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          obs_done_cyc, obs_pen_cyc;
    logic        obs_err, obs_pwrite, obs_psel_seen, obs_unstable, obs_setup_pen;
    logic [31:0] obs_rdata, obs_paddr, obs_pwdata;
    logic [3:0]  obs_psel, obs_pstrb, obs_psel_done;

    // ---------------- reference model ----------------
    function automatic logic m_hit(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(NSLV * 4096));
    endfunction

    function automatic logic [31:0] m_size(input logic [2:0] f);
        if (f[1:0] == 2'd0) return 32'd1;
        if (f[1:0] == 2'd1) return 32'd2;
        return 32'd4;
    endfunction

    function automatic logic m_bad(input logic w, input logic [31:0] a, input logic [2:0] f);
        logic legal;
        legal = w ? (f <= 3'd2) : ((f != 3'd3) && (f <= 3'd5));
        if (!legal) return 1'b1;
        if ((a % m_size(f)) != 32'd0) return 1'b1;
        return !m_hit(a);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] v, b, h;
        v = word >> (8 * (a % 4));
        b = v % 256;
        h = v % 65536;
        case (f)
            3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'd0) return 4'(32'd1 << (a % 4));
        if (f == 3'd1) return 4'(32'd3 << (a % 4));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_pwdata(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'd0) return (d % 256) * 32'h0101_0101;
        if (f == 3'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- transaction driver / monitor ----------------
    task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] f, input int waits, input logic serr, input logic noise);
        int acc, idx;
        acc = 0;
        idx = m_hit(a) ? int'((a - BASE) / 4096) : -1;
        obs_done_cyc = 0; obs_pen_cyc = 0; obs_psel_seen = 1'b0; obs_unstable = 1'b0;
        obs_err = 1'b0; obs_rdata = 32'h0; obs_psel = 4'h0; obs_psel_done = 4'h0;
        obs_pstrb = 4'h0; obs_pwdata = 32'h0; obs_paddr = 32'h0; obs_pwrite = 1'b0; obs_setup_pen = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd; func3 = f;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (apb.PSEL != 4'h0) begin
                if (!obs_psel_seen) begin
                    obs_psel = apb.PSEL; obs_pstrb = apb.PSTRB; obs_pwdata = apb.PWDATA;
                    obs_paddr = apb.PADDR; obs_pwrite = apb.PWRITE; obs_setup_pen = apb.PENABLE;
                end else if (apb.PSEL !== obs_psel || apb.PSTRB !== obs_pstrb || apb.PWDATA !== obs_pwdata ||
                             apb.PADDR !== obs_paddr || apb.PWRITE !== obs_pwrite) begin
                    obs_unstable = 1'b1;
                end
                obs_psel_seen = 1'b1;
            end
            if (apb.PENABLE) obs_pen_cyc++;
            if (done) begin
                obs_done_cyc = c; obs_err = err; obs_rdata = rdata; obs_psel_done = apb.PSEL;
                break;
            end
            // Busy-time garbage on the request inputs and non-selected slave lines must have no effect.
            req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            we    = noise ? 1'($urandom_range(0, 1)) : w;
            addr  = noise ? $urandom : a;
            wdata = noise ? $urandom : wd;
            func3 = noise ? 3'($urandom_range(0, 7)) : f;
            apb.PREADY  = noise ? 4'($urandom) : 4'h0;
            apb.PSLVERR = noise ? 4'($urandom) : 4'h0;
            if (apb.PENABLE) acc++;
            if (idx >= 0) begin
                apb.PREADY[idx]  = apb.PENABLE && (acc > waits);
                apb.PSLVERR[idx] = serr;
            end
        end
        req = 1'b0; apb.PREADY = 4'h0; apb.PSLVERR = 4'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; func3 = 3'h0;
        apb.PRDATA = '0; apb.PREADY = 4'h0; apb.PSLVERR = 4'h0;
        #1 reset = 1'b0;
        #1;
        checks++; if (apb.PSEL !== 4'h0 || apb.PENABLE !== 1'b0) begin errors++; $display("FAIL reset_apb psel=%b pen=%b exp 0", apb.PSEL, apb.PENABLE); end
        checks++; if ({done, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctl done/err/busy=%b exp 000", {done, err, busy}); end
        checks++; if (rdata !== 32'h0 || apb.PADDR !== 32'h0 || apb.PSTRB !== 4'h0 || apb.PWDATA !== 32'h0) begin
            errors++; $display("FAIL reset_data rdata=%h paddr=%h pstrb=%h pwdata=%h exp 0", rdata, apb.PADDR, apb.PSTRB, apb.PWDATA); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sw_basic;
        run_xfer(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, F3_SW, 0, 1'b0, 1'b0);
        checks++; if (obs_done_cyc !== 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", obs_done_cyc); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL sw_err got %b exp 0", obs_err); end
        checks++; if (obs_psel !== 4'b0001) begin errors++; $display("FAIL sw_psel got %b exp 0001", obs_psel); end
        checks++; if (obs_pstrb !== 4'b1111 || obs_pwrite !== 1'b1) begin errors++; $display("FAIL sw_strb_write got %b/%b exp 1111/1", obs_pstrb, obs_pwrite); end
        checks++; if (obs_pwdata !== 32'hDEAD_BEEF || obs_paddr !== 32'h1000_0004) begin
            errors++; $display("FAIL sw_bus pwdata=%h paddr=%h exp deadbeef/10000004", obs_pwdata, obs_paddr); end
        checks++; if (obs_setup_pen !== 1'b0) begin errors++; $display("FAIL sw_setup_pen got %b exp 0", obs_setup_pen); end
    endtask

    task automatic test_lb_wait;
        apb.PRDATA = {$urandom, $urandom, 32'h8000_0000, $urandom};
        run_xfer(1'b0, 32'h1000_1003, 32'h0, F3_LB, 2, 1'b0, 1'b0);
        checks++; if (obs_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", obs_rdata); end
        checks++; if (obs_done_cyc !== 5) begin errors++; $display("FAIL lb_latency got %0d exp 5", obs_done_cyc); end
        checks++; if (obs_pen_cyc !== 3) begin errors++; $display("FAIL lb_penable_cycles got %0d exp 3", obs_pen_cyc); end
        checks++; if (obs_psel !== 4'b0010 || obs_pstrb !== 4'h0) begin errors++; $display("FAIL lb_psel_strb got %b/%b exp 0010/0000", obs_psel, obs_pstrb); end
    endtask

    task automatic test_misalign;
        run_xfer(1'b1, 32'h1000_2001, 32'h1234_5678, F3_SH, 0, 1'b0, 1'b0);
        checks++; if (obs_done_cyc !== 1 || obs_err !== 1'b1) begin errors++; $display("FAIL misalign_resp cyc=%0d err=%b exp 1/1", obs_done_cyc, obs_err); end
        checks++; if (obs_psel_seen !== 1'b0) begin errors++; $display("FAIL misalign_psel got seen=%b exp 0", obs_psel_seen); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL misalign_busy_after got %b exp 0", busy); end
    endtask

    task automatic test_decode_miss_b2b;
        logic [31:0] w3;
        w3 = $urandom;
        apb.PRDATA = {w3, $urandom, $urandom, $urandom};
        run_xfer(1'b0, 32'h2000_0000, 32'h0, F3_LW, 0, 1'b0, 1'b0);
        checks++; if (obs_done_cyc !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
            errors++; $display("FAIL miss_resp cyc=%0d err=%b rdata=%h exp 1/1/0", obs_done_cyc, obs_err, obs_rdata); end
        checks++; if (obs_psel_seen !== 1'b0) begin errors++; $display("FAIL miss_no_apb got seen=%b exp 0", obs_psel_seen); end
        run_xfer(1'b0, 32'h1000_3008, 32'h0, F3_LW, 0, 1'b0, 1'b0);
        checks++; if (obs_done_cyc !== 3 || obs_err !== 1'b0 || obs_rdata !== w3) begin
            errors++; $display("FAIL b2b_accept cyc=%0d err=%b rdata=%h exp 3/0/%h", obs_done_cyc, obs_err, obs_rdata, w3); end
    endtask

    task automatic test_timeout;
        apb.PRDATA = {$urandom, $urandom, $urandom, $urandom};
        run_xfer(1'b0, 32'h1000_3000, 32'h0, F3_LW, 100000, 1'b0, 1'b1);
        checks++; if (obs_done_cyc !== 2 + TMO) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", obs_done_cyc, 2 + TMO); end
        checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("FAIL tmo_resp err=%b rdata=%h exp 1/0", obs_err, obs_rdata); end
        checks++; if (obs_pen_cyc !== TMO || obs_psel_done !== 4'h0) begin
            errors++; $display("FAIL tmo_bus pen_cycles=%0d psel_at_done=%b exp %0d/0000", obs_pen_cyc, obs_psel_done, TMO); end
    endtask

    task automatic test_reset_mid_access;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h1000_0000; func3 = F3_LW;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        checks++; if (apb.PENABLE !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre_access pen=%b busy=%b exp 1/1", apb.PENABLE, busy); end
        #2 reset = 1'b0;
        #1;
        checks++; if (apb.PSEL !== 4'h0 || apb.PENABLE !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async psel=%b pen=%b busy=%b exp 0/0/0", apb.PSEL, apb.PENABLE, busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b exp 0", saw_done); end
        run_xfer(1'b1, 32'h1000_0002, 32'h0000_005A, F3_SB, 0, 1'b0, 1'b0);
        checks++; if (obs_pstrb !== 4'b0100 || obs_pwdata !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL rst_sb_lanes pstrb=%b pwdata=%h exp 0100/5a5a5a5a", obs_pstrb, obs_pwdata); end
        checks++; if (obs_done_cyc !== 3 || obs_err !== 1'b0) begin errors++; $display("FAIL rst_sb_resp cyc=%0d err=%b exp 3/0", obs_done_cyc, obs_err); end
    endtask

    task automatic test_random;
        logic w, serr, bad;
        logic [2:0] f;
        logic [31:0] a, d, word;
        logic [31:0] prw [NSLV];
        int r, waits, idx;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            f = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = BASE - 32'd4 + 32'($urandom_range(0, 3));
            else if (r == 2) a = BASE + 32'h4000 + 32'($urandom_range(0, 3));
            else             a = BASE + 32'($urandom_range(0, 3)) * 32'h1000 + 32'($urandom_range(0, 4095));
            if (r > 4) a = a - (a % m_size(f));
            d = $urandom;
            waits = $urandom_range(0, 3);
            serr = ($urandom_range(0, 3) == 0);
            for (int s = 0; s < NSLV; s++) prw[s] = $urandom;
            apb.PRDATA = {prw[3], prw[2], prw[1], prw[0]};
            bad = m_bad(w, a, f);
            idx = bad ? 0 : int'((a - BASE) / 4096);
            word = prw[idx];
            run_xfer(w, a, d, f, waits, serr, 1'b1);
            checks++; if (obs_done_cyc !== (bad ? 1 : 3 + waits)) begin
                errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", n, obs_done_cyc, bad ? 1 : 3 + waits); end
            checks++; if (obs_err !== (bad | serr)) begin errors++; $display("FAIL rnd%0d_err got %b exp %b", n, obs_err, bad | serr); end
            checks++; if (obs_rdata !== ((bad | w | serr) ? 32'h0 : m_rdata(f, a, word))) begin
                errors++; $display("FAIL rnd%0d_rdata got %h exp %h", n, obs_rdata, (bad | w | serr) ? 32'h0 : m_rdata(f, a, word)); end
            if (bad) begin
                checks++; if (obs_psel_seen !== 1'b0) begin errors++; $display("FAIL rnd%0d_no_apb got seen=%b exp 0", n, obs_psel_seen); end
            end else begin
                checks++; if (obs_psel !== 4'(32'd1 << idx) || obs_paddr !== a || obs_pwrite !== w) begin
                    errors++; $display("FAIL rnd%0d_setup psel=%b paddr=%h pwrite=%b exp %b/%h/%b", n, obs_psel, obs_paddr, obs_pwrite, 4'(32'd1 << idx), a, w); end
                checks++; if (obs_pstrb !== (w ? m_strb(f, a) : 4'h0)) begin
                    errors++; $display("FAIL rnd%0d_pstrb got %b exp %b", n, obs_pstrb, w ? m_strb(f, a) : 4'h0); end
                if (w) begin
                    checks++; if (obs_pwdata !== m_pwdata(f, d)) begin errors++; $display("FAIL rnd%0d_pwdata got %h exp %h", n, obs_pwdata, m_pwdata(f, d)); end
                end
                checks++; if (obs_unstable !== 1'b0 || obs_setup_pen !== 1'b0 || obs_pen_cyc !== waits + 1) begin
                    errors++; $display("FAIL rnd%0d_phases unstable=%b setup_pen=%b pen_cycles=%0d exp 0/0/%0d", n, obs_unstable, obs_setup_pen, obs_pen_cyc, waits + 1); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_basic();
        test_lb_wait();
        test_misalign();
        test_decode_miss_b2b();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
